// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: FSM states, next-PC select codes and the
// per-stage stall/flush bundle used by the pipeline register modules.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StMdBusy  = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_EXC = 2'd2;
  localparam logic [1:0] PC_SEL_EPC = 2'd3;

  localparam int unsigned MD_CNT_W = 6;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

  // The PC has no bubble to insert, so it only carries a stall bit.
  typedef struct packed {
    logic        pc_stall;
    stage_ctrl_t ifid;
    stage_ctrl_t idex;
    stage_ctrl_t exmem;
    stage_ctrl_t memwb;
  } pipe_ctrl_t;

  function automatic logic load_use_hit(input logic       ld,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt,
                                        input logic       uses_rs,
                                        input logic       uses_rt);
    return ld && (rd != 5'd0) && ((uses_rs && (rs == rd)) || (uses_rt && (rt == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage stall/flush and PC select out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             exmem_mem_req;
  logic             mem_ready;
  logic             exmem_syscall;
  logic             exmem_eret;
  logic             exmem_br_taken;
  logic             idex_md_start;
  logic             idex_mem_r;
  logic [4:0]       idex_rd_addr;
  logic [4:0]       ifid_rs_addr;
  logic [4:0]       ifid_rt_addr;
  logic             ifid_uses_rs;
  logic             ifid_uses_rt;

  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_stall;
  logic             exmem_stall;
  logic             memwb_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic [1:0]       pc_sel;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output exmem_mem_req, mem_ready, exmem_syscall, exmem_eret, exmem_br_taken,
           idex_md_start, idex_mem_r, idex_rd_addr, ifid_rs_addr, ifid_rt_addr,
           ifid_uses_rs, ifid_uses_rt,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           pc_sel, ctrl_state, stall_cycles
  );

  modport slave (
    input  exmem_mem_req, mem_ready, exmem_syscall, exmem_eret, exmem_br_taken,
           idex_md_start, idex_mem_r, idex_rd_addr, ifid_rs_addr, ifid_rt_addr,
           ifid_uses_rs, ifid_uses_rt,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           pc_sel, ctrl_state, stall_cycles
  );
endinterface

// File: rtl/md_wait_counter.sv
// Loadable down-counter tracking remaining mult/div busy cycles; saturates at zero.
module md_wait_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller for the 5-stage core: arbitrates memory wait,
// exceptions, taken branches, mult/div occupancy and load-use stalls; counts stall cycles.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [MD_CNT_W-1:0] MdLoadVal = MD_CNT_W'(MD_LATENCY - 2);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  pipe_ctrl_t       ctrl;
  logic [1:0]       pc_sel;
  logic             md_load, md_dec, md_zero;
  logic             mem_wait, exc, lu_hit;

  assign mem_wait = hz.exmem_mem_req && !hz.mem_ready;
  assign exc      = hz.exmem_syscall || hz.exmem_eret;
  assign lu_hit   = load_use_hit(hz.idex_mem_r, hz.idex_rd_addr, hz.ifid_rs_addr,
                                 hz.ifid_rt_addr, hz.ifid_uses_rs, hz.ifid_uses_rt);

  md_wait_counter #(
    .Width (MD_CNT_W)
  ) u_md_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (md_load),
    .load_val_i (MdLoadVal),
    .dec_i      (md_dec),
    .zero_o     (md_zero)
  );

  always_comb begin
    ctrl    = '0;
    pc_sel  = PC_SEL_SEQ;
    state_d = state_q;
    md_load = 1'b0;
    md_dec  = 1'b0;
    if (reset) begin
      ctrl.ifid.flush  = 1'b1;
      ctrl.idex.flush  = 1'b1;
      ctrl.exmem.flush = 1'b1;
      ctrl.memwb.flush = 1'b1;
      state_d          = StRun;
    end else begin
      case (state_q)
        StRun, StMemWait: begin
          state_d = StRun;
          // EX/MEM is held during a memory wait, so exception/branch stay pending.
          if (mem_wait) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid.stall  = 1'b1;
            ctrl.idex.stall  = 1'b1;
            ctrl.exmem.stall = 1'b1;
            ctrl.memwb.flush = 1'b1;
            state_d          = StMemWait;
          end else if (exc) begin
            ctrl.ifid.flush  = 1'b1;
            ctrl.idex.flush  = 1'b1;
            ctrl.exmem.flush = 1'b1;
            pc_sel           = hz.exmem_syscall ? PC_SEL_EXC : PC_SEL_EPC;
          end else if (hz.exmem_br_taken) begin
            ctrl.ifid.flush  = 1'b1;
            ctrl.idex.flush  = 1'b1;
            ctrl.exmem.flush = 1'b1;
            pc_sel           = PC_SEL_BR;
          end else if (hz.idex_md_start) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid.stall  = 1'b1;
            ctrl.idex.stall  = 1'b1;
            ctrl.exmem.flush = 1'b1;
            md_load          = 1'b1;
            state_d          = StMdBusy;
          end else if (lu_hit) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid.stall = 1'b1;
            ctrl.idex.flush = 1'b1;
          end
        end
        StMdBusy: begin
          // Release cycle lets the mult/div advance; idex_md_start is not re-examined.
          if (!md_zero) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid.stall  = 1'b1;
            ctrl.idex.stall  = 1'b1;
            ctrl.exmem.flush = 1'b1;
            md_dec           = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  assign stall_cycles_d = ctrl.pc_stall ? stall_cycles_q + 1'b1 : stall_cycles_q;

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.pc_stall     = ctrl.pc_stall;
  assign hz.ifid_stall   = ctrl.ifid.stall;
  assign hz.idex_stall   = ctrl.idex.stall;
  assign hz.exmem_stall  = ctrl.exmem.stall;
  assign hz.memwb_stall  = ctrl.memwb.stall;
  assign hz.ifid_flush   = ctrl.ifid.flush;
  assign hz.idex_flush   = ctrl.idex.flush;
  assign hz.exmem_flush  = ctrl.exmem.flush;
  assign hz.memwb_flush  = ctrl.memwb.flush;
  assign hz.pc_sel       = pc_sel;
  assign hz.ctrl_state   = state_q;
  assign hz.stall_cycles = stall_cycles_q;

endmodule
